// File: rtl/module_control_pkg.sv
// Shared encodings for the Mini-CPU control stage: FSM states, opcodes and
// instruction-register field positions.
package module_control_pkg;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_CALC   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_STORE  = 3'd6;
  localparam logic [2:0] S_SHOW   = 3'd7;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_t;

  localparam int IR_W     = 18;
  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 15;
  localparam int DST_MSB  = 14;
  localparam int DST_LSB  = 11;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 7;
  localparam int SRC2_MSB = 6;
  localparam int SRC2_LSB = 3;
  localparam int SIGN_BIT = 6;
  localparam int IMM_MSB  = 5;
  localparam int IMM_LSB  = 0;

  // Register-register forms take their second operand from the bank.
  function automatic logic uses_src2(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_dest(input opcode_t op);
    return (op != OP_CLEAR) && (op != OP_DISPLAY);
  endfunction

endpackage

// File: rtl/module_regfile.sv
// 16x16 register bank: two combinational read ports, one synchronous write
// port and a synchronous clear-all that overrides the write.
module module_regfile #(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  output logic [15:0]   rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [15:0]   rd_data_b,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          clr
);

  logic [15:0] mem [NREGS];

  // NOTE: the bank is built from flops, not a RAM macro, so it can take the
  // async reset; a RAM-inferred array must never be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/module_control.sv
// Mini-CPU control stage: fetches an instruction on a send press, reads
// operands, handshakes with the ALU, writes back and latches the display.
module module_control
  import module_control_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power,
  input  logic        send,
  input  logic [17:0] instr,
  input  logic        decoded,
  input  logic        calculated,
  input  logic [15:0] valorGuardarULA,
  output logic [2:0]  stateCPU,
  output logic [2:0]  opcode,
  output logic        sinalImm,
  output logic [5:0]  Imm,
  output logic [15:0] v1ULA,
  output logic [15:0] v2ULA,
  output logic [15:0] dispValue,
  output logic [3:0]  dispReg,
  output logic [2:0]  dispOp,
  output logic        dispValid,
  output logic        timeoutErr
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [IR_W-1:0] ir;
  logic [15:0]     result;
  logic [CW-1:0]   cnt;
  logic            send_s1, send_s2, send_prev, press;
  opcode_t         op;
  logic [3:0]      dst, src1, src2;
  logic [3:0]      rd_addr_a;
  logic [15:0]     rd_data_a, rd_data_b;
  logic            rf_we, rf_clr;

  assign op    = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign dst   = ir[DST_MSB:DST_LSB];
  assign src1  = ir[SRC1_MSB:SRC1_LSB];
  assign src2  = ir[SRC2_MSB:SRC2_LSB];
  assign press = send_s2 & ~send_prev;

  // History is primed as "pressed" so a button held through reset needs a
  // release before it can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_s1   <= 1'b1;
      send_s2   <= 1'b1;
      send_prev <= 1'b1;
    end else begin
      send_s1   <= send;
      send_s2   <= send_s1;
      send_prev <= send_s2;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_addr_a = src1;
    if (state == S_SHOW && op != OP_DISPLAY) rd_addr_a = dst;
  end

  assign rf_we  = (state == S_STORE) && writes_dest(op);
  assign rf_clr = !power || ((state == S_STORE) && (op == OP_CLEAR));

  module_regfile #(.NREGS(NREGS), .AW(4)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (src2),
    .rd_data_b (rd_data_b),
    .we        (rf_we),
    .wr_addr   (dst),
    .wr_data   (result),
    .clr       (rf_clr)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      ir         <= '0;
      result     <= '0;
      cnt        <= '0;
      v1ULA      <= '0;
      v2ULA      <= '0;
      dispValue  <= '0;
      dispReg    <= '0;
      dispOp     <= '0;
      dispValid  <= 1'b0;
      timeoutErr <= 1'b0;
    end else if (!power) begin
      state      <= S_OFF;
      ir         <= '0;
      result     <= '0;
      cnt        <= '0;
      v1ULA      <= '0;
      v2ULA      <= '0;
      dispValue  <= '0;
      dispReg    <= '0;
      dispOp     <= '0;
      dispValid  <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      case (state)
        S_OFF: state <= S_FETCH;
        S_FETCH: begin
          if (press) begin
            ir    <= instr;
            cnt   <= '0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (decoded) begin
            state <= S_READ;
          end else if (cnt == TO_LAST) begin
            timeoutErr <= 1'b1;
            state      <= S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ: begin
          v1ULA <= rd_data_a;
          v2ULA <= uses_src2(op) ? rd_data_b : 16'h0000;
          cnt   <= '0;
          state <= S_CALC;
        end
        S_CALC: begin
          if (calculated) begin
            result <= valorGuardarULA;
            state  <= S_WAIT;
          end else if (cnt == TO_LAST) begin
            timeoutErr <= 1'b1;
            state      <= S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT:  state <= S_STORE;
        S_STORE: state <= S_SHOW;
        S_SHOW: begin
          // The bank already holds the STORE write, giving write-first display.
          dispValue  <= rd_data_a;
          dispReg    <= rd_addr_a;
          dispOp     <= ir[OP_MSB:OP_LSB];
          dispValid  <= 1'b1;
          timeoutErr <= 1'b0;
          state      <= S_FETCH;
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign stateCPU = state;
  assign opcode   = ir[OP_MSB:OP_LSB];
  assign sinalImm = ir[SIGN_BIT];
  assign Imm      = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_module_control.sv
// Directed bench for module_control with a one-cycle-late ALU handshake model.
module tb_module_control;
  import module_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, power, send;
  logic [17:0] instr;
  logic        decoded, calculated;
  logic [15:0] valorGuardarULA;
  logic [2:0]  stateCPU, opcode, dispOp;
  logic        sinalImm, dispValid, timeoutErr;
  logic [5:0]  Imm;
  logic [15:0] v1ULA, v2ULA, dispValue;
  logic [3:0]  dispReg;

  module_control dut (
    .clk(clk), .rst_n(rst_n), .power(power), .send(send), .instr(instr),
    .decoded(decoded), .calculated(calculated), .valorGuardarULA(valorGuardarULA),
    .stateCPU(stateCPU), .opcode(opcode), .sinalImm(sinalImm), .Imm(Imm),
    .v1ULA(v1ULA), .v2ULA(v2ULA), .dispValue(dispValue), .dispReg(dispReg),
    .dispOp(dispOp), .dispValid(dispValid), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  bit          alu_dec_en  = 1'b1;
  bit          alu_calc_en = 1'b1;
  logic [15:0] alu_result  = '0;

  // ALU model: registers its done flags, so each answers one cycle late.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded         <= 1'b0;
      calculated      <= 1'b0;
      valorGuardarULA <= '0;
    end else begin
      decoded         <= alu_dec_en  && (stateCPU == S_DECODE);
      calculated      <= alu_calc_en && (stateCPU == S_CALC);
      valorGuardarULA <= alu_result;
    end
  end

  int          total = 0;
  int          bad   = 0;
  int          trace[$];
  logic [15:0] cap_v1, cap_v2;
  int          norm_seq [9] = '{2, 2, 3, 4, 4, 5, 6, 7, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rf(input logic [3:0] i);
    return dut.u_rf.mem[i];
  endfunction

  function automatic int nonzero_regs();
    int n = 0;
    for (int i = 0; i < 16; i++) if (rf(4'(i)) != 16'h0) n++;
    return n;
  endfunction

  function automatic logic [17:0] mk(input logic [2:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [6:0] low);
    return {op, d, s1, low};
  endfunction

  function automatic int count_state(input int s);
    int n = 0;
    foreach (trace[i]) if (trace[i] == s) n++;
    return n;
  endfunction

  task automatic check_normal(input string tag);
    check({tag, "_len"}, trace.size(), 9);
    if (trace.size() == 9)
      for (int i = 0; i < 9; i++) check({tag, "_seq"}, trace[i], norm_seq[i]);
  endtask

  // mode: 0 normal, 1 send pulse in CALC, 2 power-off in CALC, 3 reset in STORE
  task automatic run(input logic [17:0] w, input logic [15:0] res, input int mode);
    int  n;
    int  pc;
    bit  pulsed;
    bit  done;
    trace.delete();
    instr = w;
    alu_result = res;
    send = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stateCPU != S_DECODE && n < 20);
    send = 1'b0;
    if (stateCPU != S_DECODE) begin
      check("reach_decode", stateCPU, S_DECODE);
      return;
    end
    pulsed = 1'b0;
    pc = 0;
    done = 1'b0;
    n = 0;
    while (!done) begin
      trace.push_back(int'(stateCPU));
      if (stateCPU == S_CALC) begin
        cap_v1 = v1ULA;
        cap_v2 = v2ULA;
      end
      if (stateCPU == S_FETCH || stateCPU == S_OFF) begin
        done = 1'b1;
      end else if (n >= 40) begin
        check("instr_done", stateCPU, S_FETCH);
        done = 1'b1;
      end else begin
        if (mode == 1) begin
          if (!pulsed && stateCPU == S_CALC) begin
            send = 1'b1;
            pulsed = 1'b1;
          end else if (pulsed && pc < 2) begin
            pc++;
            if (pc == 2) send = 1'b0;
          end
        end
        if (mode == 2 && stateCPU == S_CALC) power = 1'b0;
        if (mode == 3 && stateCPU == S_STORE) begin
          #1 rst_n = 1'b0;
          #1;
          check("arst_state", stateCPU, S_OFF);
          check("arst_dispvalue", dispValue, 16'h0);
          check("arst_dispvalid", dispValid, 1'b0);
          check("arst_v1", v1ULA, 16'h0);
          check("arst_opcode", opcode, 3'd0);
          @(negedge clk);
          rst_n = 1'b1;
          done = 1'b1;
        end
        if (!done) begin
          @(negedge clk);
          n++;
        end
      end
    end
  endtask

  initial begin
    int stray;
    rst_n = 1'b0;
    power = 1'b0;
    send  = 1'b1;
    instr = '0;
    repeat (3) @(negedge clk);
    check("rst_state", stateCPU, S_OFF);
    check("rst_dispvalid", dispValid, 1'b0);
    check("rst_dispvalue", dispValue, 16'h0);
    check("rst_timeout", timeoutErr, 1'b0);
    check("rst_regs", nonzero_regs(), 0);

    // Button held across reset release must not fire.
    rst_n = 1'b1;
    power = 1'b1;
    @(negedge clk);
    check("pwr_fetch", stateCPU, S_FETCH);
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (stateCPU != S_FETCH) stray++;
    end
    check("held_send_ignored", stray, 0);
    send = 1'b0;
    repeat (3) @(negedge clk);

    run(mk(OP_LOAD, 4'd3, 4'd0, 7'd5), 16'd5, 0);
    check_normal("load");
    check("load_reg3", rf(4'd3), 16'd5);
    check("load_dispvalue", dispValue, 16'd5);
    check("load_dispreg", dispReg, 4'd3);
    check("load_dispvalid", dispValid, 1'b1);
    check("load_dispop", dispOp, 3'd0);
    check("load_imm", Imm, 6'd5);

    run(mk(OP_LOAD, 4'd1, 4'd0, 7'd7), 16'd7, 0);
    run(mk(OP_LOAD, 4'd2, 4'd0, 7'd9), 16'd9, 0);
    check("reg1", rf(4'd1), 16'd7);
    check("reg2", rf(4'd2), 16'd9);

    run(mk(OP_ADD, 4'd4, 4'd1, 7'b0010_000), 16'd16, 0);
    check_normal("add");
    check("add_v1", cap_v1, 16'd7);
    check("add_v2", cap_v2, 16'd9);
    check("add_reg4", rf(4'd4), 16'd16);
    check("add_dispvalue", dispValue, 16'd16);
    check("add_dispreg", dispReg, 4'd4);
    check("add_dispop", dispOp, 3'd1);

    // [6:3] points at reg1 but ADDI must present v2=0.
    run(mk(OP_ADDI, 4'd5, 4'd2, 7'b0_001000), 16'd17, 0);
    check("addi_v1", cap_v1, 16'd9);
    check("addi_v2", cap_v2, 16'd0);
    check("addi_imm", Imm, 6'd8);
    check("addi_reg5", rf(4'd5), 16'd17);

    run(mk(OP_SUBI, 4'd6, 4'd1, 7'b1_000010), 16'd5, 0);
    check("subi_sign", sinalImm, 1'b1);
    check("subi_imm", Imm, 6'd2);
    check("subi_reg6", rf(4'd6), 16'd5);

    run(mk(OP_LOAD, 4'd8, 4'd0, 7'd0), 16'h1234, 1);
    check_normal("calc_press");
    check("calc_press_reg8", rf(4'd8), 16'h1234);
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (stateCPU != S_FETCH) stray++;
    end
    check("calc_press_dropped", stray, 0);

    run(mk(OP_CLEAR, 4'd3, 4'd0, 7'd0), 16'hBEEF, 0);
    check("clear_regs", nonzero_regs(), 0);
    check("clear_dispvalue", dispValue, 16'h0);
    check("clear_dispop", dispOp, 3'd6);

    run(mk(OP_DISPLAY, 4'd6, 4'd3, 7'd0), 16'h1234, 0);
    check("disp0_value", dispValue, 16'h0);
    check("disp0_reg", dispReg, 4'd3);
    check("disp0_op", dispOp, 3'd7);
    check("disp0_nowrite", rf(4'd6), 16'h0);

    run(mk(OP_LOAD, 4'd3, 4'd0, 7'd0), 16'h00AB, 0);
    run(mk(OP_DISPLAY, 4'd6, 4'd3, 7'd0), 16'h5555, 0);
    check("disp1_value", dispValue, 16'h00AB);
    check("disp1_reg", dispReg, 4'd3);
    check("disp1_nowrite", rf(4'd6), 16'h0);

    alu_dec_en = 1'b0;
    run(mk(OP_LOAD, 4'd7, 4'd0, 7'd0), 16'h0055, 0);
    alu_dec_en = 1'b1;
    check("dto_len", trace.size(), 9);
    check("dto_decode_cycles", count_state(2), 8);
    check("dto_err", timeoutErr, 1'b1);
    check("dto_reg7", rf(4'd7), 16'h0);
    check("dto_display_kept", dispValue, 16'h00AB);

    run(mk(OP_LOAD, 4'd7, 4'd0, 7'd0), 16'd3, 0);
    check("dto_cleared", timeoutErr, 1'b0);
    check("dto_reg7_after", rf(4'd7), 16'd3);

    alu_calc_en = 1'b0;
    run(mk(OP_LOAD, 4'd9, 4'd0, 7'd0), 16'h0066, 0);
    alu_calc_en = 1'b1;
    check("cto_calc_cycles", count_state(4), 8);
    check("cto_err", timeoutErr, 1'b1);
    check("cto_reg9", rf(4'd9), 16'h0);

    run(mk(OP_LOAD, 4'd10, 4'd0, 7'd0), 16'h0077, 2);
    check("poff_state", stateCPU, S_OFF);
    check("poff_regs", nonzero_regs(), 0);
    check("poff_dispvalue", dispValue, 16'h0);
    check("poff_dispreg", dispReg, 4'd0);
    check("poff_dispvalid", dispValid, 1'b0);
    check("poff_timeout", timeoutErr, 1'b0);
    power = 1'b1;
    @(negedge clk);
    check("poff_restart", stateCPU, S_FETCH);

    run(mk(OP_LOAD, 4'd2, 4'd0, 7'd0), 16'h0077, 0);
    check("pre_arst_reg2", rf(4'd2), 16'h0077);
    run(mk(OP_LOAD, 4'd2, 4'd0, 7'd0), 16'h0099, 3);
    check("arst_nowrite", rf(4'd2), 16'h0);
    @(negedge clk);
    check("arst_restart", stateCPU, S_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
